// File: rtl/masked_output_capture.sv
// Purpose: capture a masked gadget's output shares, XOR-recombine them, check against the golden bit, count glitches.
// Latency: start accepted at edge t0 -> valid_out high for one cycle after edge t0+SETTLE_CYCLES+2.
// Backpressure: none; start is only accepted in IDLE, and a start seen while busy is dropped (not queued).
module masked_output_capture #(
  parameter int OUT_SIZE      = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int TGL_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                expected,
  input  logic [OUT_SIZE-1:0] shares,
  output logic                busy,
  output logic                valid_out,
  output logic                unmasked,
  output logic                match,
  output logic [TGL_W-1:0]    toggle_count,
  output logic [CNT_W-1:0]    trace_count,
  output logic [CNT_W-1:0]    error_count
);

  // Settle counter only needs to reach SETTLE_CYCLES-1.
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                exp_q, exp_d;
  logic [SC_W-1:0]     cnt_q, cnt_d;
  logic [OUT_SIZE-1:0] prev_q, prev_d;
  logic [OUT_SIZE-1:0] sample_q, sample_d;
  logic [TGL_W-1:0]    toggle_q, toggle_d;
  logic                unmasked_q, unmasked_d;
  logic                match_q, match_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    trace_q, trace_d;
  logic [CNT_W-1:0]    error_q, error_d;
  logic                recombined;

  // Unmasked bit is the XOR of every captured share.
  assign recombined = ^sample_q;

  // Next-state and datapath updates for the trace FSM.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    sample_d   = sample_q;
    toggle_d   = toggle_q;
    unmasked_d = unmasked_q;
    match_d    = match_q;
    valid_d    = 1'b0;
    trace_d    = trace_q;
    error_d    = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          exp_d    = expected;
          cnt_d    = '0;
          prev_d   = shares;
          toggle_d = '0;
        end
      end
      SETTLE: begin
        cnt_d  = cnt_q + SC_W'(1);
        prev_d = shares;
        // Glitch activity: any share change between consecutive settle edges, saturating.
        if ((shares != prev_q) && (toggle_q != {TGL_W{1'b1}})) begin
          toggle_d = toggle_q + TGL_W'(1);
        end
        if (cnt_q == SC_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        sample_d = shares;
        state_d  = CHECK;
      end
      CHECK: begin
        unmasked_d = recombined;
        match_d    = (recombined == exp_q);
        valid_d    = 1'b1;
        trace_d    = trace_q + CNT_W'(1);
        if ((recombined != exp_q) && (error_q != {CNT_W{1'b1}})) begin
          error_d = error_q + CNT_W'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any trace in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      exp_q      <= 1'b0;
      cnt_q      <= '0;
      prev_q     <= '0;
      sample_q   <= '0;
      toggle_q   <= '0;
      unmasked_q <= 1'b0;
      match_q    <= 1'b0;
      valid_q    <= 1'b0;
      trace_q    <= '0;
      error_q    <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      sample_q   <= sample_d;
      toggle_q   <= toggle_d;
      unmasked_q <= unmasked_d;
      match_q    <= match_d;
      valid_q    <= valid_d;
      trace_q    <= trace_d;
      error_q    <= error_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign valid_out    = valid_q;
  assign unmasked     = unmasked_q;
  assign match        = match_q;
  assign toggle_count = toggle_q;
  assign trace_count  = trace_q;
  assign error_count  = error_q;

endmodule

// File: tb/tb_masked_output_capture.sv
// Purpose: scoreboard bench for masked_output_capture (default instance A, small-counter instance B).
// Latency: expected results are queued at start and matched against valid_out including the arrival cycle.
// Backpressure: none; back-to-back starts are driven in the valid_out cycle.
module tb_masked_output_capture;

  localparam int SA = 4;
  localparam int SB = 6;

  logic        clk;
  logic        rst;
  logic        start_a, expected_a, start_b, expected_b;
  logic [1:0]  shares_a, shares_b;
  logic        busy_a, valid_a, unmasked_a, match_a;
  logic        busy_b, valid_b, unmasked_b, match_b;
  logic [7:0]  toggle_a;
  logic [15:0] trace_a, error_a;
  logic [1:0]  toggle_b, trace_b, error_b;

  int cyc;
  int checks;
  int errors;

  typedef struct {
    int   cyc;
    logic um;
    logic m;
    int   tgl;
    int   tc;
    int   ec;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  masked_output_capture #(.OUT_SIZE(2), .SETTLE_CYCLES(SA), .CNT_W(16), .TGL_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(expected_a), .shares(shares_a),
    .busy(busy_a), .valid_out(valid_a), .unmasked(unmasked_a), .match(match_a),
    .toggle_count(toggle_a), .trace_count(trace_a), .error_count(error_a)
  );

  masked_output_capture #(.OUT_SIZE(2), .SETTLE_CYCLES(SB), .CNT_W(2), .TGL_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(expected_b), .shares(shares_b),
    .busy(busy_b), .valid_out(valid_b), .unmasked(unmasked_b), .match(match_b),
    .toggle_count(toggle_b), .trace_count(trace_b), .error_count(error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitors: every valid_out pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && valid_a) begin
      exp_t e;
      chk("a_pending_result", q_a.size() > 0, 1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_valid_cycle", cyc, e.cyc);
        chk("a_unmasked", unmasked_a, e.um);
        chk("a_match", match_a, e.m);
        chk("a_toggle_count", toggle_a, e.tgl);
        chk("a_trace_count", trace_a, e.tc);
        chk("a_error_count", error_a, e.ec);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_b) begin
      exp_t e;
      chk("b_pending_result", q_b.size() > 0, 1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_valid_cycle", cyc, e.cyc);
        chk("b_unmasked", unmasked_b, e.um);
        chk("b_match", match_b, e.m);
        chk("b_toggle_count", toggle_b, e.tgl);
        chk("b_trace_count", trace_b, e.tc);
        chk("b_error_count", error_b, e.ec);
      end
    end
  end

  task automatic drive(input bit b, input logic s, input logic e, input logic [1:0] sh);
    if (b) begin
      start_b = s; expected_b = e; shares_b = sh;
    end else begin
      start_a = s; expected_a = e; shares_a = sh;
    end
  endtask

  task automatic idle(input int n);
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One trace: element i of seq is the shares value present at edge t0+i.
  // extra_i >= 1 raises a second (ignored) start at that element.
  task automatic trace(input bit b, input logic e, input logic [31:0] seq, input int extra_i,
                       input logic um, input logic m, input int tgl, input int tc, input int ec);
    int   s;
    exp_t x;
    s     = b ? SB : SA;
    x.cyc = cyc + s + 3;
    x.um  = um;
    x.m   = m;
    x.tgl = tgl;
    x.tc  = tc;
    x.ec  = ec;
    if (b) q_b.push_back(x);
    else   q_a.push_back(x);
    for (int i = 0; i <= s + 2; i++) begin
      drive(b, (i == 0) || (i == extra_i), e, seq[2*i +: 2]);
      @(negedge clk);
      if (b) chk("b_busy", busy_b, (i <= s + 1));
      else   chk("a_busy", busy_a, (i <= s + 1));
    end
  endtask

  initial begin
    logic [31:0] seq;
    int          busy_seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start_a = 1'b0; expected_a = 1'b0; shares_a = 2'b00;
    start_b = 1'b0; expected_b = 1'b0; shares_b = 2'b00;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_unmasked", unmasked_a, 0);
    chk("rst_match", match_a, 0);
    chk("rst_toggle", toggle_a, 0);
    chk("rst_trace", trace_a, 0);
    chk("rst_error", error_a, 0);
    rst = 1'b0;

    // Idle with no start: busy never rises.
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) busy_seen++;
    end
    chk("idle_busy_cycles", busy_seen, 0);

    // Correct trace, then a run of matching and mismatching traces.
    trace(0, 1'b1, {16{2'b10}}, -1, 1'b1, 1'b1, 0, 1, 0);
    idle(3);
    trace(0, 1'b0, {16{2'b11}}, -1, 1'b0, 1'b1, 0, 2, 0);
    idle(2);
    trace(0, 1'b1, {16{2'b01}}, -1, 1'b1, 1'b1, 0, 3, 0);
    idle(2);
    trace(0, 1'b0, {16{2'b01}}, -1, 1'b1, 1'b0, 0, 4, 1);
    idle(2);

    // Glitches 00->01->00->11 on settle edges 1..3, plus a start while busy.
    seq = {16{2'b11}};
    seq[1:0] = 2'b00;
    seq[3:2] = 2'b01;
    seq[5:4] = 2'b00;
    trace(0, 1'b0, seq, 2, 1'b0, 1'b1, 3, 5, 1);
    idle(10);
    chk("ignored_start_trace_count", trace_a, 5);

    // Reset two cycles after start aborts the trace.
    drive(0, 1'b1, 1'b1, 2'b10);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_valid", valid_a, 0);
    chk("abort_trace_count", trace_a, 0);
    chk("abort_error_count", error_a, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    trace(0, 1'b1, {16{2'b10}}, -1, 1'b1, 1'b1, 0, 1, 0);
    idle(2);

    // Small counters: five back-to-back mismatches, then a toggling trace.
    trace(1, 1'b1, {16{2'b00}}, -1, 1'b0, 1'b0, 0, 1, 1);
    trace(1, 1'b1, {16{2'b00}}, -1, 1'b0, 1'b0, 0, 2, 2);
    trace(1, 1'b1, {16{2'b00}}, -1, 1'b0, 1'b0, 0, 3, 3);
    trace(1, 1'b1, {16{2'b00}}, -1, 1'b0, 1'b0, 0, 0, 3);
    trace(1, 1'b1, {16{2'b00}}, -1, 1'b0, 1'b0, 0, 1, 3);
    seq = {16{2'b00}};
    for (int i = 1; i <= SB; i++) begin
      seq[2*i +: 2] = (i % 2 == 1) ? 2'b01 : 2'b00;
    end
    trace(1, 1'b0, seq, -1, 1'b0, 1'b1, 3, 2, 3);
    idle(6);

    chk("a_results_outstanding", q_a.size(), 0);
    chk("b_results_outstanding", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
